// File: rtl/pair_serializer_pkg.sv
// pair_serializer_pkg: element type, data width and FSM state encoding for pair_serializer
package pair_serializer_pkg;
  localparam int DATA_W = 8;
  typedef struct packed {
    logic              tag;
    logic [DATA_W-1:0] payload;
  } elem_t;
  typedef enum logic [1:0] {EMPTY, HOLD_FIRST, HOLD_SECOND} ser_state_e;
endpackage

// File: rtl/pair_serializer.sv
// pair_serializer: splits a masked element pair into a valid/ready stream of single elements
//   in_valid/in_ready/in_pair/in_mask : pair input, mask bit i marks element [i] present
//   out_valid/out_ready/out_elem/out_last : element output, out_last flags the pair's final element
//   elem_cnt : wrapping count of consumed elements; drop_cnt : saturating count of empty pairs
module pair_serializer
  import pair_serializer_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  elem_t [1:0]      in_pair,
  input  logic [1:0]       in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output elem_t            out_elem,
  output logic             out_last,
  output logic [CNT_W-1:0] elem_cnt,
  output logic [7:0]       drop_cnt
);
  // emission order: F is the index emitted first, S the index emitted second
  localparam int F = HIGH_FIRST ? 1 : 0;
  localparam int S = HIGH_FIRST ? 0 : 1;
  ser_state_e       state_q;
  elem_t            out_elem_q, sec_q;
  logic             out_last_q;
  logic [CNT_W-1:0] elem_cnt_q;
  logic [7:0]       drop_cnt_q;
  logic             consume, fin, accept;
  assign out_valid = state_q != EMPTY;
  assign consume   = out_valid && out_ready;
  assign fin       = consume && out_last_q;
  // a final consume frees the holding register in the same cycle, so a new pair may enter
  assign in_ready  = (state_q == EMPTY) || fin;
  assign accept    = in_valid && in_ready;
  assign out_elem  = out_elem_q;
  assign out_last  = out_last_q;
  assign elem_cnt  = elem_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_elem_q <= '0;
      sec_q      <= '0;
      out_last_q <= 1'b0;
      elem_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (consume) elem_cnt_q <= elem_cnt_q + 1'b1;
      if (accept) begin
        if (in_mask == 2'b00) begin
          state_q    <= EMPTY;
          out_last_q <= 1'b0;
          if (drop_cnt_q != 8'hff) drop_cnt_q <= drop_cnt_q + 1'b1;
        end else begin
          state_q    <= in_mask[F] ? HOLD_FIRST : HOLD_SECOND;
          out_elem_q <= in_mask[F] ? in_pair[F] : in_pair[S];
          out_last_q <= !(in_mask[F] && in_mask[S]);
          sec_q      <= in_pair[S];
        end
      end else if (fin) begin
        state_q    <= EMPTY;
        out_last_q <= 1'b0;
      end else if (consume) begin
        // only a HOLD_FIRST beat with a second element pending reaches here
        state_q    <= HOLD_SECOND;
        out_elem_q <= sec_q;
        out_last_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pair_serializer.sv
// tb_pair_serializer: directed self-checking bench for pair_serializer in both emission orders
module tb_pair_serializer;
  import pair_serializer_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  elem_t [1:0] in_pair = '0;
  logic [1:0]  in_mask = '0;
  logic        in_ready, out_valid, out_last;
  elem_t       out_elem;
  logic [15:0] elem_cnt;
  logic [7:0]  drop_cnt;
  logic        h_in_ready, h_out_valid, h_out_last;
  elem_t       h_out_elem;
  logic [15:0] h_elem_cnt;
  logic [7:0]  h_drop_cnt;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  pair_serializer #(.CNT_W(16), .HIGH_FIRST(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pair(in_pair), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_elem(out_elem), .out_last(out_last), .elem_cnt(elem_cnt), .drop_cnt(drop_cnt)
  );
  pair_serializer #(.CNT_W(16), .HIGH_FIRST(1'b1)) u_hf (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_pair(in_pair), .in_mask(in_mask), .out_valid(h_out_valid), .out_ready(out_ready),
    .out_elem(h_out_elem), .out_last(h_out_last), .elem_cnt(h_elem_cnt), .drop_cnt(h_drop_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [8:0] e0, input logic [8:0] e1, input logic [1:0] m);
    in_valid   = v;
    in_pair[0] = e0;
    in_pair[1] = e1;
    in_mask    = m;
    #1;
  endtask
  initial begin
    int idx;
    logic saw_beat;
    logic [6:0] exp_ir;
    logic [8:0] exp_e;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_elem", out_elem, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_elem_cnt", elem_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    step();
    // full pair, both orders
    out_ready = 1'b1;
    drive(1, 9'h011, 9'h122, 2'b11);
    chk("t1_in_ready_empty", in_ready, 1);
    step();
    drive(0, 9'h000, 9'h000, 2'b00);
    chk("t1_b1_valid", out_valid, 1);
    chk("t1_b1_elem", out_elem, 9'h011);
    chk("t1_b1_last", out_last, 0);
    chk("t1_b1_in_ready", in_ready, 0);
    chk("t1_hf_b1_elem", h_out_elem, 9'h122);
    chk("t1_hf_b1_last", h_out_last, 0);
    step();
    chk("t1_b2_elem", out_elem, 9'h122);
    chk("t1_b2_last", out_last, 1);
    chk("t1_b2_in_ready", in_ready, 1);
    chk("t1_hf_b2_elem", h_out_elem, 9'h011);
    chk("t1_hf_b2_last", h_out_last, 1);
    step();
    chk("t1_empty", out_valid, 0);
    chk("t1_elem_cnt", elem_cnt, 2);
    chk("t1_hf_elem_cnt", h_elem_cnt, 2);
    // single-element pairs back to back
    drive(1, 9'h033, 9'h144, 2'b10);
    step();
    drive(1, 9'h055, 9'h166, 2'b01);
    chk("t2_a_elem", out_elem, 9'h144);
    chk("t2_a_last", out_last, 1);
    chk("t2_a_in_ready", in_ready, 1);
    step();
    drive(0, 9'h000, 9'h000, 2'b00);
    chk("t2_b_valid", out_valid, 1);
    chk("t2_b_elem", out_elem, 9'h055);
    chk("t2_b_last", out_last, 1);
    step();
    chk("t2_empty", out_valid, 0);
    chk("t2_elem_cnt", elem_cnt, 4);
    // three full pairs streamed
    exp_ir = 7'b1010101;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      drive(idx < 3, {1'b0, 8'hA0 + 8'(idx)}, {1'b1, 8'hB0 + 8'(idx)}, 2'b11);
      chk($sformatf("t3_in_ready_c%0d", c), in_ready, exp_ir[6-c]);
      chk($sformatf("t3_valid_c%0d", c), out_valid, c != 0);
      if (c != 0) begin
        exp_e = (c % 2 == 1) ? {1'b0, 8'hA0 + 8'((c - 1) / 2)} : {1'b1, 8'hB0 + 8'((c - 2) / 2)};
        chk($sformatf("t3_elem_c%0d", c), out_elem, exp_e);
      end
      if (in_valid && in_ready) idx++;
      step();
    end
    drive(0, 9'h000, 9'h000, 2'b00);
    chk("t3_empty", out_valid, 0);
    chk("t3_elem_cnt", elem_cnt, 10);
    // downstream stall in HOLD_FIRST with another pair offered
    out_ready = 1'b0;
    drive(1, 9'h077, 9'h188, 2'b11);
    step();
    drive(1, 9'h099, 9'h1AA, 2'b11);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4_elem_c%0d", c), out_elem, 9'h077);
      chk($sformatf("t4_in_ready_c%0d", c), in_ready, 0);
      chk($sformatf("t4_cnt_c%0d", c), elem_cnt, 10);
      step();
    end
    drive(0, 9'h000, 9'h000, 2'b00);
    out_ready = 1'b1;
    #1;
    chk("t4_release_elem", out_elem, 9'h077);
    step();
    chk("t4_second_elem", out_elem, 9'h188);
    chk("t4_second_last", out_last, 1);
    step();
    chk("t4_empty", out_valid, 0);
    chk("t4_elem_cnt", elem_cnt, 12);
    chk("t4_drop_zero", drop_cnt, 0);
    // 260 empty pairs saturate drop_cnt
    saw_beat = 1'b0;
    drive(1, 9'h0FF, 9'h1FF, 2'b00);
    for (int c = 0; c < 260; c++) begin
      if (out_valid) saw_beat = 1'b1;
      step();
    end
    drive(0, 9'h000, 9'h000, 2'b00);
    chk("t5_no_beats", saw_beat, 0);
    chk("t5_drop_sat", drop_cnt, 255);
    chk("t5_elem_cnt", elem_cnt, 12);
    // reset while holding the second element
    drive(1, 9'h0C1, 9'h1C2, 2'b11);
    step();
    drive(0, 9'h000, 9'h000, 2'b00);
    step();
    out_ready = 1'b0;
    #1;
    chk("t6_hold_second", out_elem, 9'h1C2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_elem", out_elem, 0);
    chk("t6_rst_last", out_last, 0);
    chk("t6_rst_cnt", elem_cnt, 0);
    chk("t6_rst_drop", drop_cnt, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    #1;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    drive(1, 9'h0D1, 9'h1D2, 2'b11);
    step();
    drive(0, 9'h000, 9'h000, 2'b00);
    chk("t6_b1_elem", out_elem, 9'h0D1);
    step();
    chk("t6_b2_elem", out_elem, 9'h1D2);
    step();
    chk("t6_elem_cnt", elem_cnt, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
